sync_delay_ctrl: RTL and testbench

Programmable sync-pulse scheduler that sequences the `delay` datapath in its SYNC role. A single-cycle `sync_in` pulse arms a down-counter. `sync_out` fires exactly `delay_reg + 1` cycles later. Pulses that arrive while the counter is busy are counted as missed. The block sits between the system sync distribution and the downstream `delay`/counter chain, and gives each chain a runtime-adjustable sync alignment.

---
 rtl/sync_delay_ctrl.sv | 122 ++++++++++++
 tb/tb_sync_delay_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sync_delay_ctrl.sv
// sync_delay_ctrl: programmable sync-pulse scheduler.
// A sync_in pulse arms a down-counter, and sync_out fires delay_reg + 1 cycles
// later. A pulse that arrives while the counter is busy is reported as missed.
// Optional feature macro: SYNC_DELAY_CTRL_RETRIGGER_EN. When it is defined, a
// pulse that arrives mid-count restarts the count, and the in-flight pulse is dropped.
module sync_delay_ctrl #(
    parameter string       ARCHITECTURE  = "BEHAVIORAL",
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned DEFAULT_DELAY = 0,
    parameter int unsigned MISS_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] delay_val,
    input  logic                   load,
    input  logic                   sync_in,
    output logic                   sync_out,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   missed,
    output logic [MISS_WIDTH-1:0]  miss_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    // All vendor flavours share the behavioural implementation.
    if (ARCHITECTURE != "BEHAVIORAL" && ARCHITECTURE != "VIRTEX5" &&
        ARCHITECTURE != "VIRTEX6") begin : g_bad_arch
        $error("sync_delay_ctrl: unsupported ARCHITECTURE");
    end

    logic [0:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] delay_q, delay_d;
    logic                   sync_out_q, sync_out_d;
    logic                   missed_q, missed_d;
    logic [MISS_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
    logic                   arm_c;

    // Next-state logic. cnt is held at zero in IDLE, so it drives count_out directly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = load ? delay_val : delay_q;
        sync_out_d = 1'b0;
        missed_d   = 1'b0;
        miss_cnt_d = miss_cnt_q;
        arm_c      = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    arm_c = sync_in;
                end
                ST_COUNT: begin
                    if (cnt_q == '0) begin
                        sync_out_d = 1'b1;
                        state_d    = ST_IDLE;
                        arm_c      = sync_in;
                    end else begin
                        cnt_d = cnt_q - COUNT_WIDTH'(1);
                        if (sync_in) begin
                            missed_d = 1'b1;
                            if (miss_cnt_q != '1) begin
                                miss_cnt_d = miss_cnt_q + MISS_WIDTH'(1);
                            end
`ifdef SYNC_DELAY_CTRL_RETRIGGER_EN
                            arm_c = 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // An arm always uses the delay that was in place before this edge.
            if (arm_c) begin
                if (delay_q == '0) begin
                    sync_out_d = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else begin
                    state_d = ST_COUNT;
                    cnt_d   = delay_q - COUNT_WIDTH'(1);
                end
            end else if (state_d == ST_IDLE) begin
                cnt_d = '0;
            end
        end
    end

    // State registers. An asynchronous reset aborts any count that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            delay_q    <= COUNT_WIDTH'(DEFAULT_DELAY);
            sync_out_q <= 1'b0;
            missed_q   <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            sync_out_q <= sync_out_d;
            missed_q   <= missed_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign sync_out  = sync_out_q;
    assign busy      = (state_q == ST_COUNT);
    assign count_out = cnt_q;
    assign missed    = missed_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// Directed bench for sync_delay_ctrl (default parameters).
// Cycle c is the interval after the c-th rising edge of a scenario. Inputs are
// driven and outputs are sampled 1 ns after that edge.
module tb_sync_delay_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] delay_val;
    logic        load;
    logic        sync_in;
    logic        sync_out;
    logic        busy;
    logic [15:0] count_out;
    logic        missed;
    logic [7:0]  miss_cnt;

    int checks = 0;
    int errors = 0;

    sync_delay_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .delay_val (delay_val),
        .load      (load),
        .sync_in   (sync_in),
        .sync_out  (sync_out),
        .busy      (busy),
        .count_out (count_out),
        .missed    (missed),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Load a new delay value during one cycle while sync_in is idle.
    task automatic do_load(input logic [15:0] v);
        load = 1'b1; delay_val = v; sync_in = 1'b0;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; delay_val = '0; load = 1'b0; sync_in = 1'b0;
        tick(); tick();
        chk("rst_sync_out", 32'(sync_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_missed", 32'(missed), 0);
        chk("rst_miss_cnt", 32'(miss_cnt), 0);
        rst = 1'b0;
        tick();

        // Scenario 1: delay 5. The pulse is in cycle 0, so sync_out is high in cycle 6.
        do_load(16'd5);
        for (int c = 0; c <= 8; c++) begin
            sync_in = (c == 0);
            chk("s1_sync_out", 32'(sync_out), 32'(c == 6));
            chk("s1_busy", 32'(busy), 32'(c >= 1 && c <= 5));
            chk("s1_count", 32'(count_out), (c >= 1 && c <= 5) ? 32'(5 - c) : 0);
            tick();
        end
        sync_in = 1'b0;

        // Scenario 2: delay 0. Pulses in cycles 3, 4 and 5 give sync_out in cycles 4, 5 and 6.
        do_load(16'd0);
        for (int c = 0; c <= 8; c++) begin
            sync_in = (c >= 3 && c <= 5);
            chk("s2_sync_out", 32'(sync_out), 32'(c >= 4 && c <= 6));
            chk("s2_busy", 32'(busy), 0);
            chk("s2_miss_cnt", 32'(miss_cnt), 0);
            tick();
        end
        sync_in = 1'b0;

        // Scenario 3: delay 3, with sync_in in cycles 0, 2 and 4.
        do_load(16'd3);
        for (int c = 0; c <= 10; c++) begin
            sync_in = (c == 0 || c == 2 || c == 4);
`ifdef SYNC_DELAY_CTRL_RETRIGGER_EN
            chk("s3_sync_out", 32'(sync_out), 32'(c == 8));
            chk("s3_missed", 32'(missed), 32'(c == 3 || c == 5));
            chk("s3_busy", 32'(busy), 32'(c >= 1 && c <= 7));
`else
            chk("s3_sync_out", 32'(sync_out), 32'(c == 4 || c == 8));
            chk("s3_missed", 32'(missed), 32'(c == 3));
            chk("s3_busy", 32'(busy), 32'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
`endif
            tick();
        end
        sync_in = 1'b0;
`ifdef SYNC_DELAY_CTRL_RETRIGGER_EN
        chk("s3_miss_cnt", 32'(miss_cnt), 2);
`else
        chk("s3_miss_cnt", 32'(miss_cnt), 1);
`endif

        // Scenario 4: delay 4, with en low in cycles 2-3. sync_out moves from cycle 5 to cycle 7.
        do_load(16'd4);
        for (int c = 0; c <= 9; c++) begin
            sync_in = (c == 0);
            en = !(c == 2 || c == 3);
            chk("s4_sync_out", 32'(sync_out), 32'(c == 7));
            chk("s4_busy", 32'(busy), 32'(c >= 1 && c <= 6));
            tick();
        end
        sync_in = 1'b0; en = 1'b1;

        // Scenario 5: delay 6, with a load of 2 in cycle 2 while busy.
        do_load(16'd6);
        for (int c = 0; c <= 15; c++) begin
            sync_in = (c == 0 || c == 10);
            load = (c == 2);
            delay_val = 16'd2;
            chk("s5_sync_out", 32'(sync_out), 32'(c == 7 || c == 13));
            chk("s5_busy", 32'(busy), 32'((c >= 1 && c <= 6) || (c >= 11 && c <= 12)));
            tick();
        end
        sync_in = 1'b0; load = 1'b0;

        // Scenario 6: an asynchronous reset lands mid-count with delay 100.
        do_load(16'd100);
        for (int c = 0; c < 20; c++) begin
            sync_in = (c == 0);
            tick();
        end
        sync_in = 1'b0;
        chk("s6_busy_pre", 32'(busy), 1);
        chk("s6_count_pre", 32'(count_out), 80);
        #3 rst = 1'b1;
        #1;
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_count", 32'(count_out), 0);
        chk("s6_rst_miss_cnt", 32'(miss_cnt), 0);
        chk("s6_rst_sync_out", 32'(sync_out), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 110; c++) begin
            chk("s6_no_sync_out", 32'(sync_out), 0);
            tick();
        end

        // Hold sync_in high to reject many pulses. 99 are rejected per round of 100 cycles.
        do_load(16'd100);
        sync_in = 1'b1;
        for (int c = 0; c <= 400; c++) begin
            if (c == 100) begin
                chk("s6_miss_cnt_100", 32'(miss_cnt), 99);
                chk("s6_missed_100", 32'(missed), 1);
                chk("s6_sync_out_100", 32'(sync_out), 0);
            end
            if (c == 101) begin
                chk("s6_sync_out_101", 32'(sync_out), 1);
                chk("s6_missed_101", 32'(missed), 0);
                chk("s6_count_101", 32'(count_out), 99);
            end
            if (c == 300) chk("s6_miss_sat_300", 32'(miss_cnt), 255);
            if (c == 400) chk("s6_miss_sat_400", 32'(miss_cnt), 255);
            tick();
        end
        sync_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
